// File: rtl/des128_pkg.sv
// Shared widths, round count and controller state encoding for the
// 128-bit expanded-DES round datapath.
package des128_pkg;

    localparam int unsigned NUM_ROUNDS = 16;
    localparam int unsigned HALF_W     = 64;
    localparam int unsigned RKEY_W     = 96;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned KIDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } round_state_t;

endpackage

// File: rtl/des128_round_ctrl_if.sv
// Block handshake, key-store fetch and result signals of the round controller.
interface des128_round_ctrl_if;
    import des128_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [BLOCK_W-1:0]   in_block;
    logic                 in_decrypt;
    logic [KIDX_W-1:0]    key_idx;
    logic [RKEY_W-1:0]    round_key;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLOCK_W-1:0]   out_block;
    logic                 busy;

    // Controller side
    modport slave (
        input  in_valid, in_block, in_decrypt, round_key, out_ready,
        output in_ready, key_idx, out_valid, out_block, busy
    );

    // Block source, key store and result sink side
    modport master (
        output in_valid, in_block, in_decrypt, round_key, out_ready,
        input  in_ready, key_idx, out_valid, out_block, busy
    );

endinterface

// File: rtl/F_FUNCTION.sv
// Combinational Feistel round function: 64-bit half mixed with a 96-bit round key.
module F_FUNCTION
    import des128_pkg::*;
(
    input  logic [HALF_W-1:0] R,
    input  logic [RKEY_W-1:0] Key,
    output logic [HALF_W-1:0] F_out
);

    logic [HALF_W-1:0] t;
    logic [HALF_W-1:0] rot_l3;
    logic [HALF_W-1:0] rot_r7;

    assign t      = R ^ Key[HALF_W-1:0];
    assign rot_l3 = {t[HALF_W-4:0], t[HALF_W-1:HALF_W-3]};
    assign rot_r7 = {t[6:0], t[HALF_W-1:7]};

    // AND term supplies the nonlinearity; upper key word whitens both halves
    assign F_out  = rot_l3 ^ (t & rot_r7) ^ {2{Key[RKEY_W-1:HALF_W]}};

endmodule

// File: rtl/des128_round_ctrl.sv
// Iterative 16-round Feistel controller sharing one F_FUNCTION instance and
// fetching one round key per cycle from the external key store.
module des128_round_ctrl
    import des128_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    des128_round_ctrl_if.slave   bus
);

    localparam logic [KIDX_W-1:0] LAST_CNT = KIDX_W'(NUM_ROUNDS - 1);

    round_state_t        state_q, state_d;
    logic [HALF_W-1:0]   l_q, l_d;
    logic [HALF_W-1:0]   r_q, r_d;
    logic                dec_q, dec_d;
    logic [KIDX_W-1:0]   cnt_q, cnt_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [KIDX_W-1:0]   cnt_nxt;
    logic [HALF_W-1:0]   f_out;

    F_FUNCTION u_f (
        .R     (r_q),
        .Key   (bus.round_key),
        .F_out (f_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            dec_q   <= 1'b0;
            cnt_q   <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            kidx_q  <= kidx_d;
        end
    end

    // Key index is registered one cycle ahead so it lines up with its round
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        kidx_d  = kidx_q;
        cnt_nxt = cnt_q + KIDX_W'(1);

        case (state_q)
            IDLE: begin
                kidx_d = '0;
                if (bus.in_valid) begin
                    l_d     = bus.in_block[BLOCK_W-1:HALF_W];
                    r_d     = bus.in_block[HALF_W-1:0];
                    dec_d   = bus.in_decrypt;
                    cnt_d   = '0;
                    kidx_d  = bus.in_decrypt ? LAST_CNT : '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ f_out;
                cnt_d = cnt_nxt;
                if (cnt_q == LAST_CNT) begin
                    kidx_d  = '0;
                    state_d = DONE;
                end else begin
                    kidx_d = dec_q ? (LAST_CNT - cnt_nxt) : cnt_nxt;
                end
            end
            DONE: begin
                kidx_d = '0;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                kidx_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.key_idx   = kidx_q;
    // Final swap: result leaves as {R16, L16}
    assign bus.out_block = {r_q, l_q};

endmodule

// File: tb/tb_des128_round_ctrl.sv
// Directed self-checking bench for des128_round_ctrl with an independent Feistel model.
module tb_des128_round_ctrl;
    import des128_pkg::*;

    localparam logic [127:0] BLK_A = 128'he054f0aae054f0aa_e054f0aae054f0aa;
    localparam logic [127:0] BLK_B = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] BLK_C = 128'hdeadbeefcafef00d_0badc0de12345678;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [3:0] kseq [16];

    des128_round_ctrl_if bus ();

    des128_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] key_of(input logic [3:0] i);
        return {24'h1b02ef + 24'(i), 72'hdb49a51b02efdb49a5};
    endfunction

    assign bus.round_key = key_of(bus.key_idx);

    function automatic logic [63:0] f_model(input logic [63:0] r, input logic [95:0] k);
        logic [63:0] t;
        t = r ^ k[63:0];
        return ((t << 3) | (t >> 61)) ^ (t & ((t >> 7) | (t << 57))) ^ {k[95:64], k[95:64]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input logic dec);
        logic [63:0] l, r, t;
        l = blk[127:64];
        r = blk[63:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ f_model(r, key_of(dec ? 4'(15 - i) : 4'(i)));
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block from IDLE, records key indices and waits (bounded) for the result
    task automatic run_block(input logic [127:0] blk, input logic dec,
                             output logic [127:0] got, output int lat);
        bus.in_valid   = 1'b1;
        bus.in_block   = blk;
        bus.in_decrypt = dec;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (lat < 16) kseq[lat] = bus.key_idx;
            tick();
            lat++;
        end
        got = bus.out_block;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.key_idx !== 4'd0) begin bad++; $display("FAIL reset_key_idx got=%0d exp=0", bus.key_idx); end
        total++; if (bus.out_block !== 128'd0) begin bad++; $display("FAIL reset_out_block got=%h exp=0", bus.out_block); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dir(input string name, input logic [127:0] blk, input logic dec,
                            input logic [127:0] exp_blk, output logic [127:0] got);
        int lat;
        bus.out_ready = 1'b0;
        run_block(blk, dec, got, lat);
        total++; if (lat !== 16) begin bad++; $display("FAIL %s_latency got=%0d exp=16", name, lat); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (kseq[k] !== (dec ? 4'(15 - k) : 4'(k))) begin
                bad++;
                $display("FAIL %s_key_idx[%0d] got=%0d exp=%0d", name, k, kseq[k], dec ? 15 - k : k);
            end
        end
        total++; if (got !== exp_blk) begin bad++; $display("FAIL %s_out_block got=%h exp=%h", name, got, exp_blk); end
        total++; if (bus.key_idx !== 4'd0) begin bad++; $display("FAIL %s_done_key_idx got=%0d exp=0", name, bus.key_idx); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL %s_done_in_ready got=%b exp=0", name, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL %s_back_to_idle got=%b%b exp=10", name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_a;
        int lat;
        exp_a = model(BLK_A, 1'b0);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_block   = BLK_A;
        bus.in_decrypt = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid   = 1'b1;
        bus.in_block   = BLK_B;
        bus.in_decrypt = 1'b1;
        total++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL bp_round_ready_busy got=%b%b exp=01", bus.in_ready, bus.busy);
        end
        tick();
        bus.in_valid = 1'b0;
        lat = 6;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        total++; if (lat !== 16) begin bad++; $display("FAIL bp_latency got=%0d exp=16", lat); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_block !== exp_a) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%b%b %h exp=10 %h", c, bus.out_valid, bus.in_ready, bus.out_block, exp_a);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL bp_release got=%b%b exp=10", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int lat;
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_block   = BLK_B;
        bus.in_decrypt = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (bus.key_idx !== 4'd6) begin bad++; $display("FAIL mid_round7_key_idx got=%0d exp=6", bus.key_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_abort got=%b%b%b exp=100", bus.in_ready, bus.busy, bus.out_valid);
        end
        run_block(BLK_C, 1'b0, got, lat);
        total++; if (lat !== 16) begin bad++; $display("FAIL mid_fresh_latency got=%0d exp=16", lat); end
        total++; if (got !== model(BLK_C, 1'b0)) begin bad++; $display("FAIL mid_fresh_block got=%h exp=%h", got, model(BLK_C, 1'b0)); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc_t [2];
        logic [127:0] res [2];
        int accepts, results;
        accepts = 0;
        results = 0;
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_block   = BLK_B;
        bus.in_decrypt = 1'b0;
        for (int cyc = 0; cyc < 80 && results < 2; cyc++) begin
            total++;
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
                bad++; $display("FAIL b2b_ready_and_valid got=11 exp=not-both cyc=%0d", cyc);
            end
            if (bus.in_ready && bus.in_valid && accepts < 2) begin acc_t[accepts] = cyc; accepts++; end
            if (bus.out_valid && results < 2) begin res[results] = bus.out_block; results++; end
            tick();
            if (accepts == 1) bus.in_block = BLK_C;
            if (accepts == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        total++; if (accepts != 2 || results != 2) begin
            bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", accepts, results);
        end else begin
            total++; if (acc_t[1] - acc_t[0] != 18) begin bad++; $display("FAIL b2b_spacing got=%0d exp=18", acc_t[1] - acc_t[0]); end
            total++; if (res[0] !== model(BLK_B, 1'b0)) begin bad++; $display("FAIL b2b_res0 got=%h exp=%h", res[0], model(BLK_B, 1'b0)); end
            total++; if (res[1] !== model(BLK_C, 1'b0)) begin bad++; $display("FAIL b2b_res1 got=%h exp=%h", res[1], model(BLK_C, 1'b0)); end
        end
    endtask

    initial begin
        logic [127:0] enc;
        logic [127:0] dec_res;
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_block   = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_dir("enc", BLK_A, 1'b0, model(BLK_A, 1'b0), enc);
        test_dir("dec", enc, 1'b1, BLK_A, dec_res);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
